// File: rtl/mcdf_sched_pkg.sv
// rtl/mcdf_sched_pkg.sv - shared constants, state type and length decode for the MCDF scheduler
// Contents: CH_NUM, PRIO_W, PKGSEL_W, CNT_W, ID_W, state_t, pkglen_decode().
package mcdf_sched_pkg;

  localparam int CH_NUM   = 3;
  localparam int PRIO_W   = 2;
  localparam int PKGSEL_W = 3;
  localparam int CNT_W    = 6;
  localparam int ID_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Beats per packet for a length select; every select above 3 saturates at 32.
  function automatic logic [CNT_W-1:0] pkglen_decode(input logic [PKGSEL_W-1:0] sel);
    logic [CNT_W-1:0] beats;
    case (sel)
      3'd0:    beats = 6'd4;
      3'd1:    beats = 6'd8;
      3'd2:    beats = 6'd16;
      default: beats = 6'd32;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mcdf_prio_rr_pick.sv
// rtl/mcdf_prio_rr_pick.sv - combinational priority picker with round-robin tie-break
// Ports: req (requesting channels), prio (per-channel priority, 0 = highest),
//        last_winner (previous grant; search starts one past it),
//        winner (picked channel id), win (at least one channel requested).
module mcdf_prio_rr_pick
  import mcdf_sched_pkg::*;
(
  input  logic [CH_NUM-1:0]             req,
  input  logic [CH_NUM-1:0][PRIO_W-1:0] prio,
  input  logic [ID_W-1:0]               last_winner,
  output logic [ID_W-1:0]               winner,
  output logic                          win
);

  logic [PRIO_W-1:0] best_prio;
  logic [2:0]        idx;

  // Walk channels in RR order; a later channel only displaces the current
  // pick with a strictly better priority, so equal priorities keep RR order.
  always_comb begin
    winner    = '0;
    win       = 1'b0;
    best_prio = '1;
    idx       = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = {1'b0, last_winner} + 3'(k);
      if (idx >= 3'(CH_NUM)) idx = idx - 3'(CH_NUM);
      if (req[idx[1:0]] && (!win || (prio[idx[1:0]] < best_prio))) begin
        win       = 1'b1;
        winner    = idx[1:0];
        best_prio = prio[idx[1:0]];
      end
    end
  end

endmodule

// File: rtl/mcdf_wrr_sched.sv
// rtl/mcdf_wrr_sched.sv - packet-level priority/RR scheduler between slave FIFOs and formatter
// Optional feature macro: STARVE_GUARD_EN (per-channel age counters force a grant).
// Ports: clk_i, rstn_i (async active-low); slv_prio_i/slv_pkglen_i per-channel config;
//        slv_req_i/slv_val_i/slv_data_i from channel FIFOs, a2s_ack_o pops them;
//        f2a_id_req_i/f2a_ack_i from formatter; a2f_val_o/a2f_id_o/a2f_data_o/
//        a2f_pkglen_sel_o to formatter; busy_o while a packet is in flight.
module mcdf_wrr_sched
  import mcdf_sched_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef STARVE_GUARD_EN
  , parameter int AGE_MAX = 4
`endif
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [CH_NUM-1:0][PRIO_W-1:0] slv_prio_i,
  input  logic [CH_NUM-1:0][PKGSEL_W-1:0] slv_pkglen_i,
  input  logic [CH_NUM-1:0]             slv_req_i,
  input  logic [CH_NUM-1:0]             slv_val_i,
  input  logic [CH_NUM-1:0][DATA_W-1:0] slv_data_i,
  output logic [CH_NUM-1:0]             a2s_ack_o,
  input  logic                          f2a_id_req_i,
  input  logic                          f2a_ack_i,
  output logic                          a2f_val_o,
  output logic [ID_W-1:0]               a2f_id_o,
  output logic [DATA_W-1:0]             a2f_data_o,
  output logic [PKGSEL_W-1:0]           a2f_pkglen_sel_o,
  output logic                          busy_o
);

  state_t                        state, state_nxt;
  logic [ID_W-1:0]               id_q, last_q;
  logic [PKGSEL_W-1:0]           sel_q;
  logic [CNT_W-1:0]              tgt_q, cnt_q;
  logic [CH_NUM-1:0][PRIO_W-1:0] eff_prio;
  logic [ID_W-1:0]               pick_id;
  logic                          pick_win;
  logic                          grant;
  logic                          beat_acc;
  logic                          last_beat;

`ifdef STARVE_GUARD_EN
  logic [CH_NUM-1:0][2:0] age_q;

  // An aged channel competes as top priority; RR still orders aged peers.
  always_comb begin
    eff_prio = slv_prio_i;
    for (int i = 0; i < CH_NUM; i++) begin
      if (int'(age_q[i]) >= AGE_MAX) eff_prio[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      age_q <= '0;
    end else if (grant) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (ID_W'(i) == pick_id)             age_q[i] <= '0;
        else if (slv_req_i[i] && age_q[i] != 3'd7) age_q[i] <= age_q[i] + 3'd1;
      end
    end
  end
`else
  assign eff_prio = slv_prio_i;
`endif

  mcdf_prio_rr_pick u_pick (
    .req         (slv_req_i),
    .prio        (eff_prio),
    .last_winner (last_q),
    .winner      (pick_id),
    .win         (pick_win)
  );

  assign grant     = (state == ARB) && pick_win;
  assign beat_acc  = (state == XFER) && slv_val_i[id_q] && f2a_ack_i;
  assign last_beat = beat_acc && (cnt_q == tgt_q - 6'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f2a_id_req_i) state_nxt = ARB;
      ARB:     if (pick_win)     state_nxt = XFER;
      XFER:    if (last_beat)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a2f_val_o  = 1'b0;
    a2f_data_o = '0;
    a2s_ack_o  = '0;
    busy_o     = 1'b0;
    if (state == XFER) begin
      a2f_val_o       = slv_val_i[id_q];
      a2f_data_o      = slv_data_i[id_q];
      a2s_ack_o[id_q] = beat_acc;
      busy_o          = 1'b1;
    end
  end

  assign a2f_id_o         = id_q;
  assign a2f_pkglen_sel_o = sel_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      id_q   <= '0;
      sel_q  <= '0;
      tgt_q  <= '0;
      cnt_q  <= '0;
      last_q <= 2'd2;
    end else begin
      state <= state_nxt;
      if (grant) begin
        // Config is sampled here only; later changes wait for the next ARB.
        id_q  <= pick_id;
        sel_q <= slv_pkglen_i[pick_id];
        tgt_q <= pkglen_decode(slv_pkglen_i[pick_id]);
        cnt_q <= '0;
      end else if (last_beat) begin
        cnt_q  <= '0;
        last_q <= id_q;
      end else if (beat_acc) begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mcdf_wrr_sched.sv
// tb/tb_mcdf_wrr_sched.sv - self-checking randomized bench for mcdf_wrr_sched
module tb_mcdf_wrr_sched;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic [2:0][1:0] slv_prio;
  logic [2:0][2:0] slv_pkglen;
  logic [2:0]      slv_req;
  logic [2:0]      slv_val;
  logic [2:0][31:0] slv_data;
  logic [2:0]      a2s_ack;
  logic            f2a_id_req;
  logic            f2a_ack;
  logic            a2f_val;
  logic [1:0]      a2f_id;
  logic [31:0]     a2f_data;
  logic [2:0]      a2f_pkglen_sel;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int exp_last = 2;

  always #5 clk = ~clk;

  mcdf_wrr_sched dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .slv_prio_i       (slv_prio),
    .slv_pkglen_i     (slv_pkglen),
    .slv_req_i        (slv_req),
    .slv_val_i        (slv_val),
    .slv_data_i       (slv_data),
    .a2s_ack_o        (a2s_ack),
    .f2a_id_req_i     (f2a_id_req),
    .f2a_ack_i        (f2a_ack),
    .a2f_val_o        (a2f_val),
    .a2f_id_o         (a2f_id),
    .a2f_data_o       (a2f_data),
    .a2f_pkglen_sel_o (a2f_pkglen_sel),
    .busy_o           (busy)
  );

  // Reference: packet length in beats.
  function automatic int exp_beats(input int sel);
    return (sel >= 3) ? 32 : (4 << sel);
  endfunction

  // Reference: lowest (priority, distance past last winner) key wins.
  function automatic int exp_winner(input logic [2:0] req, input logic [2:0][1:0] prio,
                                    input int last);
    int best = -1;
    int best_key = 1000;
    for (int c = 0; c < 3; c++) begin
      int key;
      key = int'(prio[c]) * 3 + ((c - last - 1 + 6) % 3);
      if (req[c] && key < best_key) begin
        best_key = key;
        best = c;
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    rstn_i     = 1'b0;
    f2a_id_req = 1'b0;
    f2a_ack    = 1'b0;
    slv_req    = '0;
    slv_val    = '0;
    slv_data   = '0;
    slv_prio   = '0;
    slv_pkglen = '0;
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
    exp_last = 2;
  endtask

  // Drives one packet through with random gaps/acks and reports what it observed.
  task automatic do_packet(input int gap_pct, input int ack_pct, output int id,
                           output int sel, output int beats, output int errs,
                           output bit tmo);
    logic [2:0]       sv_req = slv_req;
    logic [2:0][1:0]  sv_prio = slv_prio;
    logic [2:0][2:0]  sv_len = slv_pkglen;
    logic [2:0]       exp_ack;
    bit started = 0;
    int n = 0;
    id = -1; sel = -1; beats = 0; errs = 0; tmo = 0;
    f2a_id_req = 1'b1;
    while (n < 1000) begin
      @(posedge clk); #1;
      if (started && !busy) break;
      if (started) begin
        slv_req    = 3'($urandom);
        slv_prio   = 6'($urandom);
        slv_pkglen = 9'($urandom);
      end
      for (int c = 0; c < 3; c++) begin
        slv_val[c]  = ($urandom_range(99, 0) >= gap_pct);
        slv_data[c] = $urandom;
      end
      f2a_ack = ($urandom_range(99, 0) < ack_pct);
      #1;
      if (busy) begin
        if (!started) begin
          started = 1;
          id  = int'(a2f_id);
          sel = int'(a2f_pkglen_sel);
        end
        exp_ack = '0;
        exp_ack[id] = slv_val[id] & f2a_ack;
        if (a2f_val !== slv_val[id] || a2f_data !== slv_data[id] || a2s_ack !== exp_ack ||
            int'(a2f_id) != id || int'(a2f_pkglen_sel) != sel)
          errs++;
        if (slv_val[id] && f2a_ack) beats++;
      end else begin
        if (a2f_val !== 1'b0 || a2s_ack !== 3'b000 || a2f_data !== 32'd0) errs++;
      end
      n++;
    end
    if (!started || n >= 1000) tmo = 1;
    slv_req    = sv_req;
    slv_prio   = sv_prio;
    slv_pkglen = sv_len;
  endtask

  task automatic test_reset();
    do_reset();
    rstn_i = 1'b0;
    slv_req = 3'b111; slv_val = 3'b111; f2a_ack = 1'b1; f2a_id_req = 1'b1;
    slv_data = {32'h1, 32'h2, 32'h3}; slv_pkglen = {3'd5, 3'd6, 3'd7};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a2s_ack, a2f_val, a2f_id, a2f_data, a2f_pkglen_sel, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b val=%b id=%0d data=%h sel=%0d busy=%b want all 0",
               a2s_ack, a2f_val, a2f_id, a2f_data, a2f_pkglen_sel, busy);
    end
  endtask

  task automatic test_rr_equal();
    int id, sel, beats, errs;
    bit tmo;
    int exp_ids[4] = '{0, 1, 2, 0};
    do_reset();
    slv_req = 3'b111; slv_prio = '0; slv_pkglen = '0;
    for (int p = 0; p < 4; p++) begin
      do_packet(0, 100, id, sel, beats, errs, tmo);
      checks++;
      if (tmo || id != exp_ids[p] || beats != 4 || errs != 0) begin
        failures++;
        $display("FAIL rr_equal pkt%0d got id=%0d beats=%0d errs=%0d tmo=%0d want id=%0d beats=4 errs=0",
                 p, id, beats, errs, tmo, exp_ids[p]);
      end
    end
  endtask

  task automatic test_priority();
    int id, sel, beats, errs;
    bit tmo;
    do_reset();
    slv_req = 3'b111;
    slv_prio[0] = 2'd3; slv_prio[1] = 2'd1; slv_prio[2] = 2'd0;
    for (int p = 0; p < 3; p++) begin
      slv_pkglen = 9'($urandom);
      do_packet(10, 80, id, sel, beats, errs, tmo);
      checks++;
      if (tmo || id != 2 || sel != int'(slv_pkglen[2]) ||
          beats != exp_beats(int'(slv_pkglen[2])) || errs != 0) begin
        failures++;
        $display("FAIL priority pkt%0d got id=%0d sel=%0d beats=%0d errs=%0d tmo=%0d want id=2 sel=%0d",
                 p, id, sel, beats, errs, tmo, slv_pkglen[2]);
      end
    end
  endtask

  task automatic test_valid_gap();
    int n = 0, k = 0, low = 0, beats = 0, id = -1;
    do_reset();
    slv_req = 3'b010; slv_pkglen[1] = 3'd2;
    f2a_ack = 1'b1; f2a_id_req = 1'b1; slv_val = 3'b111;
    while (!busy && n < 50) begin
      @(posedge clk); #2; n++;
    end
    f2a_id_req = 1'b0;
    while (busy && k < 100) begin
      if (id < 0) id = int'(a2f_id);
      if (!a2f_val) low++;
      if (a2f_val && f2a_ack) beats++;
      @(posedge clk); #1;
      k++;
      slv_val[1] = !(k >= 5 && k <= 7);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (id != 1 || beats != 16 || low != 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL valid_gap got id=%0d beats=%0d low=%0d busy=%b want id=1 beats=16 low=3 busy=0",
               id, beats, low, busy);
    end
  endtask

  task automatic test_arb_hold();
    int id, sel, beats, errs, held = 0;
    bit tmo;
    do_reset();
    slv_req = 3'b000; f2a_id_req = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy === 1'b0 && a2f_val === 1'b0) held++;
    end
    checks++;
    if (held != 10) begin
      failures++;
      $display("FAIL arb_hold got idle_cycles=%0d want 10", held);
    end
    slv_req = 3'b001; slv_pkglen[0] = 3'd6;
    do_packet(20, 70, id, sel, beats, errs, tmo);
    checks++;
    if (tmo || id != 0 || sel != 6 || beats != 32 || errs != 0) begin
      failures++;
      $display("FAIL arb_release got id=%0d sel=%0d beats=%0d errs=%0d tmo=%0d want id=0 sel=6 beats=32",
               id, sel, beats, errs, tmo);
    end
  endtask

  task automatic test_reset_mid();
    int id, sel, beats, errs, acc = 0, n = 0;
    bit tmo;
    do_reset();
    slv_req = 3'b111; slv_pkglen = {3'd1, 3'd1, 3'd1};
    slv_val = 3'b111; f2a_ack = 1'b1; f2a_id_req = 1'b1;
    slv_data = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    while (acc < 5 && n < 100) begin
      @(posedge clk); #1;
      if (busy && a2f_val && f2a_ack) acc++;
      n++;
    end
    @(posedge clk); #1;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (acc != 5 || {a2s_ack, a2f_val, a2f_id, a2f_data, a2f_pkglen_sel, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid got acc=%0d ack=%b val=%b id=%0d data=%h busy=%b want acc=5 all 0",
               acc, a2s_ack, a2f_val, a2f_id, a2f_data, busy);
    end
    @(posedge clk); #1 rstn_i = 1'b1;
    exp_last = 2;
    do_packet(0, 100, id, sel, beats, errs, tmo);
    checks++;
    if (tmo || id != 0 || beats != 8 || errs != 0) begin
      failures++;
      $display("FAIL reset_mid_regrant got id=%0d beats=%0d errs=%0d tmo=%0d want id=0 beats=8",
               id, beats, errs, tmo);
    end
  endtask

  task automatic test_random();
    int id, sel, beats, errs, exp_id;
    bit tmo;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      slv_req = 3'($urandom_range(7, 1));
      slv_prio = 6'($urandom);
      slv_pkglen = 9'($urandom);
      exp_id = exp_winner(slv_req, slv_prio, exp_last);
      do_packet(25, 70, id, sel, beats, errs, tmo);
      checks++;
      if (tmo || id != exp_id || sel != int'(slv_pkglen[exp_id]) ||
          beats != exp_beats(int'(slv_pkglen[exp_id])) || errs != 0) begin
        failures++;
        $display("FAIL random pkt%0d got id=%0d sel=%0d beats=%0d errs=%0d tmo=%0d want id=%0d sel=%0d beats=%0d",
                 p, id, sel, beats, errs, tmo, exp_id, slv_pkglen[exp_id],
                 exp_beats(int'(slv_pkglen[exp_id])));
      end
      exp_last = exp_id;
    end
  endtask

`ifdef STARVE_GUARD_EN
  task automatic test_starve();
    int id, sel, beats, errs;
    bit tmo;
    int exp_ids[5] = '{0, 0, 0, 0, 1};
    do_reset();
    slv_req = 3'b011; slv_prio[0] = 2'd0; slv_prio[1] = 2'd3;
    for (int p = 0; p < 5; p++) begin
      do_packet(0, 100, id, sel, beats, errs, tmo);
      checks++;
      if (tmo || id != exp_ids[p] || errs != 0) begin
        failures++;
        $display("FAIL starve pkt%0d got id=%0d errs=%0d tmo=%0d want id=%0d",
                 p, id, errs, tmo, exp_ids[p]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_equal();
    test_priority();
    test_valid_gap();
    test_arb_hold();
    test_reset_mid();
`ifdef STARVE_GUARD_EN
    test_starve();
`else
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
